// File: rtl/pll_lock_sequencer_if.sv
// Bundles the PLL-facing and system-facing signals of the lock sequencer.
// The master modport is the sequencer; the slave modport is its environment.
interface pll_lock_sequencer_if #(
   parameter int MAX_RETRIES = 3
) ();
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic               restart;
   logic               pll_locked;
   logic               pll_rst;
   logic               sys_rst;
   logic               ready;
   logic               lock_fail;
   logic [RETRY_W-1:0] retry_cnt;
   logic [7:0]         lol_count;

   modport master (
      input  restart,
      input  pll_locked,
      output pll_rst,
      output sys_rst,
      output ready,
      output lock_fail,
      output retry_cnt,
      output lol_count
   );

   modport slave (
      output restart,
      output pll_locked,
      input  pll_rst,
      input  sys_rst,
      input  ready,
      input  lock_fail,
      input  retry_cnt,
      input  lol_count
   );
endinterface

// File: rtl/pll_lock_sequencer.sv
// Power-up / recovery sequencer for a single-output PLL: holds the PLL in reset,
// waits for a stable lock with bounded retries, then releases the system reset.
module pll_lock_sequencer #(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int LOCK_TIMEOUT    = 50000,
   parameter int LOCK_STABLE     = 1024,
   parameter int MAX_RETRIES     = 3,
   parameter int CNT_W           = 16
) (
   input logic                  refclk,
   input logic                  rst,
   pll_lock_sequencer_if.master bus
);
   localparam int RETRY_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   localparam logic [CNT_W-1:0]   HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(LOCK_STABLE - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRIES);

   typedef enum logic [2:0] {
      S_HOLD,
      S_WAIT,
      S_STAB,
      S_RUN,
      S_FAIL
   } state_t;

   state_t             state;
   state_t             state_n;
   logic [CNT_W-1:0]   cnt;
   logic [CNT_W-1:0]   cnt_n;
   logic [RETRY_W-1:0] retry_q;
   logic [RETRY_W-1:0] retry_n;
   logic [7:0]         lol_q;
   logic [7:0]         lol_n;
   logic               sync1;
   logic               lk;

   // restart overrides the FSM; cnt is cleared on every state change
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      retry_n = retry_q;
      lol_n   = lol_q;
      if (bus.restart) begin
         state_n = S_HOLD;
         cnt_n   = '0;
         retry_n = '0;
      end else begin
         case (state)
            S_HOLD: begin
               if (cnt == HOLD_LAST) begin
                  state_n = S_WAIT;
                  cnt_n   = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_WAIT: begin
               if (lk) begin
                  state_n = S_STAB;
                  cnt_n   = '0;
               end else if (cnt == TIMEOUT_LAST) begin
                  cnt_n = '0;
                  if (retry_q == RETRY_MAX) begin
                     state_n = S_FAIL;
                  end else begin
                     state_n = S_HOLD;
                     retry_n = retry_q + 1'b1;
                  end
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_STAB: begin
               // Any dropout restarts qualification and the lock timeout
               if (!lk) begin
                  state_n = S_WAIT;
                  cnt_n   = '0;
               end else if (cnt == STABLE_LAST) begin
                  state_n = S_RUN;
                  cnt_n   = '0;
                  retry_n = '0;
               end else begin
                  cnt_n = cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!lk) begin
                  state_n = S_HOLD;
                  cnt_n   = '0;
                  if (lol_q != 8'hFF) begin
                     lol_n = lol_q + 1'b1;
                  end
               end
            end
            S_FAIL: begin
               cnt_n = '0;
            end
            default: begin
               state_n = S_HOLD;
               cnt_n   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they move with the state register
   always_ff @(posedge refclk) begin
      if (rst) begin
         state         <= S_HOLD;
         cnt           <= '0;
         retry_q       <= '0;
         lol_q         <= '0;
         sync1         <= 1'b0;
         lk            <= 1'b0;
         bus.pll_rst   <= 1'b1;
         bus.sys_rst   <= 1'b1;
         bus.ready     <= 1'b0;
         bus.lock_fail <= 1'b0;
      end else begin
         sync1         <= bus.pll_locked;
         lk            <= sync1;
         state         <= state_n;
         cnt           <= cnt_n;
         retry_q       <= retry_n;
         lol_q         <= lol_n;
         bus.pll_rst   <= (state_n == S_HOLD) || (state_n == S_FAIL);
         bus.sys_rst   <= (state_n != S_RUN);
         bus.ready     <= (state_n == S_RUN);
         bus.lock_fail <= (state_n == S_FAIL);
      end
   end

   assign bus.retry_cnt = retry_q;
   assign bus.lol_count = lol_q;

endmodule
